// File: rtl/uart_pkg.sv
// uart_pkg -- shared constants and types for the UART receive path.
//
// Holds the receiver state encoding, the default bit period and the frame
// geometry used by uart_rx and its sub-modules.
//   DEFAULT_CLK_PER_BIT : clk cycles per serial bit (87)
//   DATA_BITS           : data bits per frame (8, sent LSB first)
//   CNT_W / IDX_W       : widths of the bit-period counter and bit index
//   even_parity()       : parity bit value that makes the ones count even
package uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 87;
  localparam int DATA_BITS           = 8;
  localparam int CNT_W               = 16;
  localparam int IDX_W               = 3;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_PARITY  = 3'd3,
    RX_STOP    = 3'd4,
    RX_RECOVER = 3'd5
  } rx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- two-flop synchronizer for the asynchronous rx line.
//
// Both flops reset to 1 so a line that is idle through reset never looks
// like a start bit when reset is released.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   rx    : raw serial line (asynchronous to clk)
//   rxs   : rx retimed into the clk domain, two cycles of latency
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rxs
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = rx;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rxs = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is
// defined.
//
// The start bit is confirmed at its midpoint, after which every following
// bit is sampled one full bit period later, i.e. at the middle of each bit.
//   CLK_PER_BIT : clk cycles per serial bit (4..65535)
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   rx          : serial line, idle high
//   data_out    : last byte received without error
//   data_valid  : one-cycle pulse, data_out has just been updated
//   frame_err   : one-cycle pulse, stop bit sampled low
//   parity_err  : one-cycle pulse, parity mismatch (constant 0 in 8N1 builds)
//   busy        : high whenever the receiver is not idle
//
// Build option: define UART_RX_PARITY_EN to expect an even parity bit
// between the data bits and the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLK_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rxs;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rxs   (rxs)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic bit_end;
  assign bit_end = (clk_cnt_q == BIT_LAST);

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rxs) begin
          state_d = RX_START;
        end
      end

      // A line that is high again at mid start bit was only a glitch.
      RX_START: begin
        if (clk_cnt_q == HALF_BIT) begin
          clk_cnt_d = '0;
          if (rxs) begin
            state_d = RX_IDLE;
          end else begin
            state_d   = RX_DATA;
            bit_idx_d = '0;
          end
        end
      end

      RX_DATA: begin
        if (bit_end) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rxs;
          bit_idx_d          = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      // The mismatch is only remembered here; it is reported at the stop
      // bit so that a framing error can take precedence over it.
      RX_PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          par_bad_d = (rxs != even_parity(shift_q));
          state_d   = RX_STOP;
        end
      end
`endif

      RX_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (!rxs) begin
            frame_err_d = 1'b1;
            state_d     = RX_RECOVER;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
            state_d      = RX_IDLE;
`endif
          end else begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            state_d      = RX_IDLE;
          end
        end
      end

      // A break or stuck-low line must not be seen as a stream of frames.
      RX_RECOVER: begin
        clk_cnt_d = '0;
        if (rxs) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        clk_cnt_d = '0;
        state_d   = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif
  assign busy       = (state_q != RX_IDLE);

endmodule
